// File: rtl/ysyx_040066_mem_responder.sv
// Memory-side responder for the CPU data bus: serves single and 8-beat line
// reads/writes from a held request and drives a single-port synchronous SRAM.
`timescale 1ns/1ps
module ysyx_040066_mem_responder #(
   parameter logic [63:0] BASE      = 64'h8000_0000,
   parameter int          SIZE_LOG2 = 27,
   parameter int          MEM_AW    = SIZE_LOG2 - 3
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              rd_req,
   input  logic              rd_burst,
   input  logic [2:0]        rd_len,
   input  logic [63:0]       rd_addr,
   output logic              rd_ready,
   output logic              rd_last,
   output logic              rd_err,
   output logic [63:0]       rd_data,

   input  logic              wr_req,
   input  logic              wr_burst,
   input  logic [2:0]        wr_len,
   input  logic [7:0]        wr_mask,
   input  logic [63:0]       wr_addr,
   input  logic [511:0]      wr_data,
   output logic              wr_ready,
   output logic              wr_err,

   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic [63:0]       mem_rdata
);

   typedef enum logic [2:0] {IDLE, RD, WR, RESP, DROP} state_t;

   state_t            state_reg;
   logic [2:0]        beat_reg;
   logic              burst_reg;
   logic              served_wr_reg;
   logic [MEM_AW-1:0] base_reg;

   logic              rd_ready_reg, rd_last_reg, rd_err_reg;
   logic              wr_ready_reg, wr_err_reg;
   logic              mem_en_reg, mem_we_reg;
   logic [MEM_AW-1:0] mem_addr_reg;
   logic [63:0]       mem_wdata_reg;
   logic [7:0]        mem_wmask_reg;

   // Request selection and decode; the write channel wins a tie.
   logic              sel_wr;
   logic              sel_burst;
   logic [2:0]        sel_len;
   logic [63:0]       sel_addr;
   logic [63:0]       addr_off;
   logic              in_range;
   logic              misaligned;
   logic              req_err;
   logic [MEM_AW-1:0] req_word;

   always_comb begin
      sel_wr     = wr_req;
      sel_burst  = sel_wr ? wr_burst : rd_burst;
      sel_len    = sel_wr ? wr_len   : rd_len;
      sel_addr   = sel_wr ? wr_addr  : rd_addr;
      addr_off   = sel_addr - BASE;
      in_range   = (sel_addr >= BASE) && ((addr_off >> SIZE_LOG2) == 64'd0);
      misaligned = 1'b0;
      if (!sel_burst) begin
         case (sel_len)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = sel_addr[0];
            3'd2:    misaligned = |sel_addr[1:0];
            3'd3:    misaligned = |sel_addr[2:0];
            default: misaligned = 1'b1;
         endcase
      end
      req_err  = !in_range || misaligned;
      req_word = sel_addr[MEM_AW+2:3];
      if (sel_burst) begin
         req_word[2:0] = 3'b000;
      end
   end

   logic [2:0]        beat_next;
   logic [2:0]        last_beat;
   logic [MEM_AW-1:0] addr_next;
   logic [63:0]       wdata_next;

   assign beat_next  = beat_reg + 3'd1;
   assign last_beat  = burst_reg ? 3'd7 : 3'd0;
   assign addr_next  = base_reg + MEM_AW'(beat_next);
   // Write data is taken from the held request bus on every beat, not latched.
   assign wdata_next = wr_data[{beat_next, 6'd0} +: 64];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         beat_reg      <= 3'd0;
         burst_reg     <= 1'b0;
         served_wr_reg <= 1'b0;
         base_reg      <= '0;
         rd_ready_reg  <= 1'b0;
         rd_last_reg   <= 1'b0;
         rd_err_reg    <= 1'b0;
         wr_ready_reg  <= 1'b0;
         wr_err_reg    <= 1'b0;
         mem_en_reg    <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= 64'd0;
         mem_wmask_reg <= 8'd0;
      end else begin
         // Response strobes are single-cycle pulses unless re-asserted below.
         rd_ready_reg <= 1'b0;
         rd_last_reg  <= 1'b0;
         rd_err_reg   <= 1'b0;
         wr_ready_reg <= 1'b0;
         wr_err_reg   <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (wr_req || rd_req) begin
                  served_wr_reg <= sel_wr;
                  burst_reg     <= sel_burst;
                  base_reg      <= req_word;
                  beat_reg      <= 3'd0;
                  if (req_err) begin
                     state_reg <= RESP;
                     if (sel_wr) begin
                        wr_ready_reg <= 1'b1;
                        wr_err_reg   <= 1'b1;
                     end else begin
                        rd_ready_reg <= 1'b1;
                        rd_last_reg  <= 1'b1;
                        rd_err_reg   <= 1'b1;
                     end
                  end else begin
                     state_reg     <= sel_wr ? WR : RD;
                     mem_en_reg    <= 1'b1;
                     mem_we_reg    <= sel_wr;
                     mem_addr_reg  <= req_word;
                     mem_wdata_reg <= sel_wr ? wr_data[63:0] : 64'd0;
                     mem_wmask_reg <= sel_wr ? (sel_burst ? 8'hFF : wr_mask) : 8'd0;
                  end
               end
            end

            RD: begin
               // The beat issued this cycle returns data next cycle.
               rd_ready_reg <= 1'b1;
               if (beat_reg == last_beat) begin
                  rd_last_reg  <= 1'b1;
                  mem_en_reg   <= 1'b0;
                  mem_addr_reg <= '0;
                  state_reg    <= DROP;
               end else begin
                  beat_reg     <= beat_next;
                  mem_addr_reg <= addr_next;
               end
            end

            WR: begin
               if (beat_reg == last_beat) begin
                  mem_en_reg    <= 1'b0;
                  mem_we_reg    <= 1'b0;
                  mem_addr_reg  <= '0;
                  mem_wdata_reg <= 64'd0;
                  mem_wmask_reg <= 8'd0;
                  wr_ready_reg  <= 1'b1;
                  state_reg     <= RESP;
               end else begin
                  beat_reg      <= beat_next;
                  mem_addr_reg  <= addr_next;
                  mem_wdata_reg <= wdata_next;
               end
            end

            RESP: begin
               state_reg <= DROP;
            end

            DROP: begin
               // Hold off until the served request falls so it is not replayed.
               if (served_wr_reg ? !wr_req : !rd_req) begin
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign rd_ready  = rd_ready_reg;
   assign rd_last   = rd_last_reg;
   assign rd_err    = rd_err_reg;
   assign rd_data   = (rd_ready_reg && !rd_err_reg) ? mem_rdata : 64'd0;
   assign wr_ready  = wr_ready_reg;
   assign wr_err    = wr_err_reg;
   assign mem_en    = mem_en_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign mem_wmask = mem_wmask_reg;

endmodule

// File: tb/tb_ysyx_040066_mem_responder.sv
// Bench for ysyx_040066_mem_responder: directed scenarios plus random traffic,
// checked against a byte-address memory model kept in the bench.
`timescale 1ns/1ps
module tb_ysyx_040066_mem_responder;

   localparam logic [63:0] BASE      = 64'h8000_0000;
   localparam int          SIZE_LOG2 = 16;
   localparam int          MEM_AW    = 13;

   logic              clk;
   logic              rst;
   logic              rd_req, rd_burst;
   logic [2:0]        rd_len;
   logic [63:0]       rd_addr;
   logic              rd_ready, rd_last, rd_err;
   logic [63:0]       rd_data;
   logic              wr_req, wr_burst;
   logic [2:0]        wr_len;
   logic [7:0]        wr_mask;
   logic [63:0]       wr_addr;
   logic [511:0]      wr_data;
   logic              wr_ready, wr_err;
   logic              mem_en, mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic [7:0]        mem_wmask;
   logic [63:0]       mem_rdata;

   ysyx_040066_mem_responder #(
      .BASE(BASE), .SIZE_LOG2(SIZE_LOG2), .MEM_AW(MEM_AW)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_burst(rd_burst), .rd_len(rd_len), .rd_addr(rd_addr),
      .rd_ready(rd_ready), .rd_last(rd_last), .rd_err(rd_err), .rd_data(rd_data),
      .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backing SRAM with a preload port so the bench never drives it from two processes.
   bit   [63:0]       env_mem [0:(1<<MEM_AW)-1];
   logic              poke_en;
   logic [MEM_AW-1:0] poke_idx;
   logic [63:0]       poke_data;

   always @(posedge clk) begin
      if (poke_en) begin
         env_mem[poke_idx] <= poke_data;
      end else if (mem_en && mem_we) begin
         for (int b = 0; b < 8; b++) begin
            if (mem_wmask[b]) env_mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end
      end
      if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr];
   end

   // Reference model: 64-bit words keyed by byte address / 8.
   bit [63:0] ref_mem [logic [63:0]];

   int          vectors;
   int          miscompares;
   logic [63:0] last_rd;

   function automatic logic [63:0] ref_read(input logic [63:0] w);
      return ref_mem.exists(w) ? ref_mem[w] : 64'd0;
   endfunction

   function automatic logic model_err(input logic burst, input logic [2:0] len,
                                      input logic [63:0] addr);
      logic e;
      e = (addr < BASE) || (addr >= BASE + (64'd1 << SIZE_LOG2));
      if (!burst) begin
         if (len > 3) e = 1'b1;
         else if ((addr % (64'd1 << len)) != 64'd0) e = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd"},        64'({rd_ready, rd_last, rd_err}), 64'd0);
      chk({tag, "_rd_data"},   rd_data, 64'd0);
      chk({tag, "_wr"},        64'({wr_ready, wr_err}), 64'd0);
      chk({tag, "_mem_ctl"},   64'({mem_en, mem_we, mem_wmask}), 64'd0);
      chk({tag, "_mem_addr"},  64'(mem_addr), 64'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
   endtask

   task automatic poke(input logic [63:0] addr, input logic [63:0] data);
      poke_en   = 1'b1;
      poke_idx  = MEM_AW'((addr - BASE) >> 3);
      poke_data = data;
      ref_mem[addr >> 3] = data;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Call just after a negedge. pre = idle edges the DUT needs before it can accept.
   task automatic do_read(input logic burst, input logic [2:0] len, input logic [63:0] addr,
                          input int pre, input int hold);
      logic        exp_err;
      int          n, beats, en_cnt, spur;
      logic [63:0] word;
      exp_err = model_err(burst, len, addr);
      n       = (exp_err || !burst) ? 1 : 8;
      word    = burst ? ((addr >> 6) << 3) : (addr >> 3);
      rd_req = 1'b1; rd_burst = burst; rd_len = len; rd_addr = addr;
      beats = 0; en_cnt = 0;
      for (int k = 1; k <= pre + 12 && beats < n; k++) begin
         @(negedge clk);
         if (mem_en) en_cnt++;
         if (rd_ready) begin
            chk("rd_cycle", 64'(k), 64'(exp_err ? pre + 1 : pre + 2 + beats));
            chk("rd_data", rd_data, exp_err ? 64'd0 : ref_read(word + 64'(beats)));
            chk("rd_last", 64'(rd_last), 64'(beats == n - 1));
            chk("rd_err", 64'(rd_err), 64'(exp_err));
            last_rd = rd_data;
            beats++;
         end
      end
      chk("rd_beats", 64'(beats), 64'(n));
      chk("rd_mem_en", 64'(en_cnt), exp_err ? 64'd0 : 64'(n));
      spur = 0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (rd_ready || mem_en) spur++;
      end
      if (hold > 0) chk("rd_hold_idle", 64'(spur), 64'd0);
      $display("read  burst=%0d len=%0d addr=%h err=%0d beats=%0d last=%h",
               burst, len, addr, exp_err, beats, last_rd);
      rd_req = 1'b0;
      if (exp_err) @(negedge clk);
   endtask

   task automatic do_write(input logic burst, input logic [2:0] len, input logic [7:0] mask,
                           input logic [63:0] addr, input logic [511:0] data);
      logic        exp_err;
      int          n, got, en_cnt, rd_spur;
      logic [63:0] w, old;
      exp_err = model_err(burst, len, addr);
      n       = (exp_err || !burst) ? 1 : 8;
      wr_req = 1'b1; wr_burst = burst; wr_len = len; wr_mask = mask;
      wr_addr = addr; wr_data = data;
      got = 0; en_cnt = 0; rd_spur = 0;
      for (int k = 1; k <= 12 && got == 0; k++) begin
         @(negedge clk);
         if (mem_en) en_cnt++;
         if (rd_ready) rd_spur++;
         if (wr_ready) begin
            chk("wr_cycle", 64'(k), 64'(exp_err ? 1 : n + 1));
            chk("wr_err", 64'(wr_err), 64'(exp_err));
            got = 1;
         end
      end
      chk("wr_done", 64'(got), 64'd1);
      chk("wr_mem_en", 64'(en_cnt), exp_err ? 64'd0 : 64'(n));
      chk("wr_no_rd", 64'(rd_spur), 64'd0);
      if (!exp_err) begin
         if (burst) begin
            for (int i = 0; i < 8; i++) ref_mem[((addr >> 6) << 3) + 64'(i)] = data[i*64 +: 64];
         end else begin
            w   = addr >> 3;
            old = ref_read(w);
            for (int b = 0; b < 8; b++) if (mask[b]) old[b*8 +: 8] = data[b*8 +: 8];
            ref_mem[w] = old;
         end
      end
      $display("write burst=%0d len=%0d mask=%h addr=%h err=%0d beats=%0d",
               burst, len, mask, addr, exp_err, en_cnt);
      wr_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [63:0]  a;
      logic [511:0] d;
      logic         b;
      logic [2:0]   l;
      int           sel;

      vectors = 0; miscompares = 0; last_rd = 64'd0;
      rst = 1'b0; poke_en = 1'b0; poke_idx = '0; poke_data = 64'd0;
      rd_req = 1'b0; rd_burst = 1'b0; rd_len = 3'd0; rd_addr = 64'd0;
      wr_req = 1'b0; wr_burst = 1'b0; wr_len = 3'd0; wr_mask = 8'd0;
      wr_addr = 64'd0; wr_data = '0;

      @(negedge clk);
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("post_reset");

      // Line read from an unaligned address inside the line.
      for (int i = 0; i < 8; i++) poke(BASE + 64'h40 + 64'(i*8), 64'h11 * 64'(i + 1));
      do_read(1'b1, 3'd3, BASE + 64'h47, 0, 0);
      chk("burst_last_word", last_rd, 64'h88);
      @(negedge clk);

      // Masked single write, then read back the whole word.
      poke(BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF);
      do_write(1'b0, 3'd2, 8'h0F, BASE + 64'h10, {448'd0, 64'hDEAD_BEEF_CAFE_F00D});
      @(negedge clk);
      do_read(1'b0, 3'd3, BASE + 64'h10, 0, 0);
      chk("wr_then_rd", last_rd, 64'hFFFF_FFFF_CAFE_F00D);
      @(negedge clk);

      // Both channels raised together: write first, read sees new data.
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
      rd_req = 1'b1; rd_burst = 1'b1; rd_len = 3'd3; rd_addr = BASE + 64'h80;
      do_write(1'b1, 3'd3, 8'h00, BASE + 64'h80, d);
      do_read(1'b1, 3'd3, BASE + 64'h80, 1, 0);
      chk("simul_last_word", last_rd, d[511:448]);
      @(negedge clk);

      // Error responses.
      do_read(1'b0, 3'd3, 64'h7FFF_FFF8, 0, 0);
      @(negedge clk);
      do_write(1'b0, 3'd2, 8'h0F, BASE + 64'h2, d);
      @(negedge clk);
      do_read(1'b1, 3'd3, BASE + (64'd1 << SIZE_LOG2), 0, 0);
      @(negedge clk);
      do_write(1'b0, 3'd4, 8'hFF, BASE + 64'h20, d);
      @(negedge clk);
      do_read(1'b0, 3'd3, BASE + (64'd1 << SIZE_LOG2) - 64'd8, 0, 0);
      @(negedge clk);

      // Request held past completion, then the very next one.
      do_read(1'b1, 3'd3, BASE + 64'h40, 0, 5);
      @(negedge clk);
      do_read(1'b0, 3'd3, BASE + 64'h48, 0, 0);
      @(negedge clk);

      // Asynchronous reset during beat 4 of a line read.
      rd_req = 1'b1; rd_burst = 1'b1; rd_len = 3'd3; rd_addr = BASE + 64'h40;
      for (int k = 1; k <= 5; k++) @(negedge clk);
      chk("mid_beat4_en", 64'(mem_en), 64'd1);
      chk("mid_beat4_addr", 64'(mem_addr), 64'd12);
      #2 rst = 1'b0;
      #1 chk_zero("async_rst");
      @(negedge clk);
      chk_zero("in_rst");
      rd_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      do_read(1'b1, 3'd3, BASE + 64'h40, 0, 0);
      @(negedge clk);

      // Random traffic over a few lines plus both window edges.
      for (int r = 0; r < 40; r++) begin
         sel = $urandom_range(0, 9);
         a   = BASE + 64'($urandom_range(0, 511));
         if (sel == 0) a = BASE + 64'hFF00 + 64'($urandom_range(0, 511));
         if (sel == 1) a = BASE - 64'($urandom_range(1, 64));
         b = 1'($urandom_range(0, 1));
         l = 3'($urandom_range(0, 4));
         if (!b && l <= 3'd3 && $urandom_range(0, 3) != 0) a = (a >> l) << l;
         for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
         if ($urandom_range(0, 1) == 1) do_write(b, l, 8'($urandom), a, d);
         else                           do_read(b, l, a, 0, 0);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
      $fatal(1, "watchdog");
   end

endmodule
